alu_seq_ctrl: RTL and testbench

Command-driven sequencer that sits directly upstream and downstream of the 8-bit `ALU`. It accepts one ALU command at a time over a valid/ready handshake and reads operands from a small internal register file. It drives the ALU's `a`, `b`, `ALU_sel` and `load_shift` inputs from registers, then captures `result`/`cout`/`zout`. It writes the result back to a destination register and returns a 10-bit `{z, c, r}` response, packed the same way as the ALU test vectors.

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_seq_regfile.sv | 39 +++
 rtl/alu_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned PKG_DATA_W = 8;
    localparam int unsigned PKG_NREG   = 4;
    localparam int unsigned RSP_W      = PKG_DATA_W + 2;
    localparam int unsigned Z_BIT      = 9;
    localparam int unsigned C_BIT      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: two combinational read ports, one debug read port,
// one synchronous write port and a synchronous active-low clear.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = PKG_DATA_W,
    parameter int unsigned NREG   = PKG_NREG,
    localparam int unsigned REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a_c,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b_c,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data_c
);

    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a_c  = r_regs[i_raddr_a];
    assign o_rdata_b_c  = r_regs[i_raddr_b];
    assign o_dbg_data_c = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Serialises ALU commands: reads operands from the register file, drives the
// external ALU from registers, writes the result back and returns {z, c, result}.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = PKG_DATA_W,
    parameter int unsigned NREG   = PKG_NREG,
    localparam int unsigned REG_AW = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_load,
    input  logic [1:0]          cmd_sel,
    input  logic [1:0]          cmd_shift,
    input  logic [REG_AW-1:0]   cmd_src_a,
    input  logic [REG_AW-1:0]   cmd_src_b,
    input  logic [REG_AW-1:0]   cmd_dst,
    input  logic                cmd_imm_en,
    input  logic [DATA_W-1:0]   cmd_imm,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [1:0]          alu_sel,
    output logic [1:0]          alu_load_shift,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_cout,
    input  logic                alu_zout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W+1:0]   rsp_data,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    seq_state_e        r_state;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W+1:0] r_rsp_data;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [1:0]        r_alu_sel;
    logic [1:0]        r_alu_shift;
    logic [REG_AW-1:0] r_dst;
    logic              r_c_f;
    logic              r_z_f;

    logic              w_accept;
    logic              w_we;
    logic [REG_AW-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    // cmd_ready is registered, so an accept depends only on state-aligned flops.
    assign w_accept = cmd_valid && r_cmd_ready;

    // Write-back happens either on a load accept or when leaving EXEC.
    assign w_we    = (w_accept && cmd_load) || (r_state == EXEC);
    assign w_waddr = (r_state == EXEC) ? r_dst : cmd_dst;
    assign w_wdata = (r_state == EXEC) ? alu_result : cmd_imm;

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_we         (w_we),
        .i_waddr      (w_waddr),
        .i_wdata      (w_wdata),
        .i_raddr_a    (cmd_src_a),
        .o_rdata_a_c  (w_rd_a),
        .i_raddr_b    (cmd_src_b),
        .o_rdata_b_c  (w_rd_b),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data_c (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_alu_shift <= '0;
            r_dst       <= '0;
            r_c_f       <= 1'b0;
            r_z_f       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_load) begin
                            r_rsp_data  <= {r_z_f, r_c_f, cmd_imm};
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_alu_a     <= w_rd_a;
                            r_alu_b     <= cmd_imm_en ? cmd_imm : w_rd_b;
                            r_alu_sel   <= cmd_sel;
                            r_alu_shift <= cmd_shift;
                            r_dst       <= cmd_dst;
                            r_state     <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_rsp_data  <= {alu_zout, alu_cout, alu_result};
                    r_c_f       <= alu_cout;
                    r_z_f       <= alu_zout;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign alu_a          = r_alu_a;
    assign alu_b          = r_alu_b;
    assign alu_sel        = r_alu_sel;
    assign alu_load_shift = r_alu_shift;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomised self-checking bench for alu_seq_ctrl with a behavioural ALU and
// a transaction-level register-file model.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int unsigned DW = PKG_DATA_W;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_load = 1'b0;
    logic [1:0]    cmd_sel = '0;
    logic [1:0]    cmd_shift = '0;
    logic [AW-1:0] cmd_src_a = '0;
    logic [AW-1:0] cmd_src_b = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic          cmd_imm_en = 1'b0;
    logic [DW-1:0] cmd_imm = '0;
    logic [DW-1:0] alu_a, alu_b;
    logic [1:0]    alu_sel, alu_load_shift;
    logic [DW-1:0] alu_result;
    logic          alu_cout, alu_zout;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [RSP_W-1:0] rsp_data;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] m_regs [4];
    logic          m_c = 1'b0;
    logic          m_z = 1'b0;
    logic [RSP_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    // Stand-in ALU: add/sub/and/xor followed by an optional shift/rotate.
    function automatic logic [RSP_W-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic [1:0] sel, input logic [1:0] sh);
        logic [DW:0]   t;
        logic [DW-1:0] r;
        logic          c;
        case (sel)
            2'd0:    t = {1'b0, a} + {1'b0, b};
            2'd1:    t = {1'b0, a} - {1'b0, b};
            2'd2:    t = {1'b0, a & b};
            default: t = {1'b0, a ^ b};
        endcase
        r = t[DW-1:0];
        c = t[DW];
        case (sh)
            2'd1:    begin c = r[DW-1]; r = {r[DW-2:0], 1'b0}; end
            2'd2:    begin c = r[0];    r = {1'b0, r[DW-1:1]}; end
            2'd3:    r = {r[DW-2:0], r[DW-1]};
            default: ;
        endcase
        return {(r == '0), c, r};
    endfunction

    assign {alu_zout, alu_cout, alu_result} = alu_fn(alu_a, alu_b, alu_sel, alu_load_shift);

    alu_seq_ctrl #(.DATA_W(DW), .NREG(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_load       (cmd_load),
        .cmd_sel        (cmd_sel),
        .cmd_shift      (cmd_shift),
        .cmd_src_a      (cmd_src_a),
        .cmd_src_b      (cmd_src_b),
        .cmd_dst        (cmd_dst),
        .cmd_imm_en     (cmd_imm_en),
        .cmd_imm        (cmd_imm),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_sel        (alu_sel),
        .alu_load_shift (alu_load_shift),
        .alu_result     (alu_result),
        .alu_cout       (alu_cout),
        .alu_zout       (alu_zout),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Applies the command currently on the cmd_* inputs to the reference model.
    task automatic model_apply(output logic [RSP_W-1:0] exp);
        logic [DW-1:0] b;
        b = cmd_imm_en ? cmd_imm : m_regs[cmd_src_b];
        if (cmd_load) begin
            exp = {m_z, m_c, cmd_imm};
        end else begin
            exp = alu_fn(m_regs[cmd_src_a], b, cmd_sel, cmd_shift);
            m_c = exp[C_BIT];
            m_z = exp[Z_BIT];
        end
        m_regs[cmd_dst] = exp[DW-1:0];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_c = 1'b0;
        m_z = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = AW'(i);
            #1;
            chk(tag, 32'(dbg_data), 32'(m_regs[i]));
        end
    endtask

    task automatic rand_fields(input bit allow_load);
        cmd_load   = allow_load ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_sel    = 2'($urandom);
        cmd_shift  = 2'($urandom);
        cmd_src_a  = AW'($urandom);
        cmd_src_b  = AW'($urandom);
        cmd_dst    = AW'($urandom);
        cmd_imm_en = 1'($urandom);
        cmd_imm    = DW'($urandom);
    endtask

    // One full command: accept, EXEC checks, response, optional stall, retire.
    task automatic do_cmd(input bit load, input logic [1:0] sel, input logic [1:0] sh,
                          input logic [AW-1:0] sa, input logic [AW-1:0] sb, input logic [AW-1:0] dst,
                          input bit imm_en, input logic [DW-1:0] imm, input int stall);
        logic [DW-1:0]    ea, eb, old_dst;
        logic [RSP_W-1:0] exp;
        int  n;
        bit  ok;
        @(negedge clk);
        cmd_load = load; cmd_sel = sel; cmd_shift = sh; cmd_src_a = sa; cmd_src_b = sb;
        cmd_dst = dst; cmd_imm_en = imm_en; cmd_imm = imm;
        cmd_valid = 1'b1;
        rsp_ready = 1'b0;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 10) begin
            if (cmd_ready) ok = 1'b1;
            else begin @(negedge clk); n++; end
        end
        chk("accept_wait", 32'(ok), 32'd1);
        if (!ok) begin cmd_valid = 1'b0; return; end
        ea = m_regs[sa];
        eb = imm_en ? imm : m_regs[sb];
        old_dst = m_regs[dst];
        model_apply(exp);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!load) begin
            chk("exec_a", 32'(alu_a), 32'(ea));
            chk("exec_b", 32'(alu_b), 32'(eb));
            chk("exec_sel", 32'({alu_sel, alu_load_shift}), 32'({sel, sh}));
            chk("exec_ready", 32'(cmd_ready), 32'd0);
            chk("exec_rvalid", 32'(rsp_valid), 32'd0);
            dbg_addr = dst;
            #1;
            chk("exec_dst_old", 32'(dbg_data), 32'(old_dst));
            @(negedge clk);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        // Stall with a competing command held on the input.
        if (stall > 0) begin
            cmd_load = 1'b1; cmd_dst = dst + 1'b1; cmd_imm = ~imm; cmd_valid = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'(exp));
            chk("stall_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("retire_valid", 32'(rsp_valid), 32'd0);
        chk("retire_ready", 32'(cmd_ready), 32'd1);
        dbg_addr = dst;
        #1;
        chk("wb_dbg", 32'(dbg_data), 32'(m_regs[dst]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rvalid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_data), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_sel, alu_load_shift}), 32'd0);
        check_regs("rst_regs");
    endtask

    initial begin
        int acc_cnt, rsp_cnt, cyc, last_acc;
        bit pend;
        logic [RSP_W-1:0] e;

        model_reset();
        do_reset();

        // Directed: loads then an ALU op whose add wraps to zero with carry.
        do_cmd(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 8'h0F, 0);
        chk("load_r1", 32'(rsp_data), 32'h00F);
        do_cmd(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b0, 8'hF1, 0);
        do_cmd(1'b0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 1'b0, 8'h00, 0);
        chk("add_r3", 32'(m_regs[3]), 32'h00);
        // Immediate operand with src_a == dst.
        do_cmd(1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 8'h01, 0);
        chk("alias_r1", 32'(m_regs[1]), 32'h10);
        // Load after ALU carries the previous flags.
        do_cmd(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'hA5, 0);
        // Back-pressure for 5 cycles.
        do_cmd(1'b0, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 5);
        check_regs("bp_regs");

        // Throughput: four back-to-back ALU commands with rsp_ready high.
        @(negedge clk);
        rsp_ready = 1'b1;
        rand_fields(1'b0);
        cmd_valid = 1'b1;
        acc_cnt = 0; rsp_cnt = 0; cyc = 0; last_acc = 0; pend = 1'b0;
        while (rsp_cnt < 4 && cyc < 60) begin
            if (pend) begin
                pend = 1'b0;
                if (acc_cnt < 4) rand_fields(1'b0);
                else cmd_valid = 1'b0;
            end
            if (rsp_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("tp_rsp", 32'(rsp_data), 32'(e));
                end else begin
                    chk("tp_extra_rsp", 32'(rsp_valid), 32'd0);
                end
                rsp_cnt++;
            end
            if (cmd_valid && cmd_ready) begin
                if (acc_cnt > 0) chk("tp_gap", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                model_apply(e);
                exp_q.push_back(e);
                acc_cnt++;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("tp_accepts", 32'(acc_cnt), 32'd4);
        chk("tp_rsps", 32'(rsp_cnt), 32'd4);
        check_regs("tp_regs");

        // Reset during EXEC drops the command.
        do_cmd(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b0, 8'hFF, 0);
        @(negedge clk);
        cmd_load = 1'b0; cmd_sel = 2'd0; cmd_shift = 2'd0; cmd_src_a = 2'd2; cmd_src_b = 2'd2;
        cmd_dst = 2'd2; cmd_imm_en = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_rst_exec_a", 32'(alu_a), 32'hFF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check_regs("mid_rst_regs");
        do_cmd(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h55, 0);
        chk("mid_rst_flags", 32'(rsp_data), 32'h055);

        // Random commands with random stalls.
        for (int i = 0; i < 40; i++) begin
            rand_fields(1'b1);
            do_cmd(cmd_load, cmd_sel, cmd_shift, cmd_src_a, cmd_src_b, cmd_dst,
                   cmd_imm_en, cmd_imm, int'($urandom_range(0, 3)));
        end
        check_regs("final_regs");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
